light_sequencer: RTL



---
 rtl/light_seq_pkg.sv | 34 +++
 rtl/light_sequencer_if.sv | 17 +
 rtl/light_channel_ramp.sv | 44 ++++
 rtl/light_sequencer.sv | 88 ++++++++
 4 files changed

// File: rtl/light_seq_pkg.sv
// Shared types and helpers for the light sequencer: mode encodings, channel
// ramp state and the palette-code to RGB expansion.
package light_seq_pkg;

  typedef enum logic [1:0] {
    MODE_WHITE  = 2'b00,
    MODE_MANUAL = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  typedef enum logic {
    STEADY = 1'b0,
    RAMP   = 1'b1
  } ramp_state_e;

  localparam int unsigned MAX_CH_W = 32;
  localparam int unsigned RGB_W    = 3 * MAX_CH_W;
  localparam int unsigned RGB_IW   = $clog2(RGB_W);

  // Expand a 3-bit RGB code to full-scale channels; B occupies the low ch_w bits.
  function automatic logic [RGB_W-1:0] code_to_rgb(input logic [2:0] code,
                                                   input int unsigned ch_w);
    logic [RGB_W-1:0] rgb;
    rgb = '0;
    for (int unsigned b = 0; b < 3; b++) begin
      for (int unsigned i = 0; i < MAX_CH_W; i++) begin
        if (i < ch_w) rgb[RGB_IW'(b * ch_w + i)] = code[b];
      end
    end
    return rgb;
  endfunction

endpackage

// File: rtl/light_sequencer_if.sv
// Board-side control inputs and LED-driver outputs of the light sequencer.
interface light_sequencer_if #(
  parameter int unsigned CH_W  = 8,
  parameter int unsigned N_COL = 6
);
  localparam int unsigned LIGHT_W = 3 * CH_W;
  localparam int unsigned IDX_W   = $clog2(N_COL);

  logic                     button;
  light_seq_pkg::mode_e     mode;
  logic [LIGHT_W-1:0]       light;
  logic [IDX_W-1:0]         colour_idx;
  logic                     changing;

  modport master (output button, mode, input light, colour_idx, changing);
  modport slave  (input button, mode, output light, colour_idx, changing);
endinterface

// File: rtl/light_channel_ramp.sv
// One colour channel register stepping toward its target. With
// LIGHT_SEQ_FADE_EN defined it moves FADE_STEP per cycle, otherwise it jumps.
module light_channel_ramp
  import light_seq_pkg::*;
#(
  parameter int unsigned CH_W      = 8,
  parameter int unsigned FADE_STEP = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH_W-1:0] target,
  output logic [CH_W-1:0] value,
  output logic            ramp
);

`ifdef LIGHT_SEQ_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif
  // A full-scale step makes the jump case fall out of the same compare.
  localparam logic [CH_W-1:0] STEP = FADE_EN ? CH_W'(FADE_STEP) : '1;

  ramp_state_e     state;
  logic [CH_W-1:0] value_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value <= '0;
    else     value <= value_d;
  end

  // Compare the distance before stepping so the channel never wraps.
  always_comb begin
    state   = (value == target) ? STEADY : RAMP;
    value_d = value;
    if (state == RAMP) begin
      if (target > value) value_d = ((target - value) <= STEP) ? target : value + STEP;
      else                value_d = ((value - target) <= STEP) ? target : value - STEP;
    end
  end

  assign ramp = (state == RAMP);

endmodule

// File: rtl/light_sequencer.sv
// Mode-driven RGB light sequencer: press detect, palette index, auto hold
// timer and target mux feeding three channel ramps (fade via LIGHT_SEQ_FADE_EN).
module light_sequencer
  import light_seq_pkg::*;
#(
  parameter int unsigned CH_W      = 8,
  parameter int unsigned N_COL     = 6,
  parameter int unsigned HOLD_CYC  = 50_000_000,
  parameter int unsigned FADE_STEP = 16
) (
  input logic               clk,
  input logic               rst,
  light_sequencer_if.slave  bus
);

  localparam int unsigned LIGHT_W = 3 * CH_W;
  localparam int unsigned IDX_W   = $clog2(N_COL);
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYC);

  logic                btn_q;
  logic [IDX_W-1:0]    idx_q,  idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                press;
  logic                advance;
  logic [2:0]          code;
  logic [LIGHT_W-1:0]  target;
  logic [LIGHT_W-1:0]  light_q;
  logic [2:0]          ramp;

  // btn_q resets high so a button held through reset is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q  <= 1'b1;
      idx_q  <= '0;
      hold_q <= '0;
    end else begin
      btn_q  <= bus.button;
      idx_q  <= idx_d;
      hold_q <= hold_d;
    end
  end

  // Index advance and auto hold timer; a press on terminal count advances once.
  always_comb begin
    press   = bus.button & ~btn_q;
    advance = 1'b0;
    hold_d  = '0;
    idx_d   = idx_q;
    case (bus.mode)
      MODE_MANUAL: advance = press;
      MODE_AUTO: begin
        advance = press | (hold_q == HOLD_W'(HOLD_CYC - 1));
        hold_d  = advance ? '0 : hold_q + HOLD_W'(1);
      end
      default: ;
    endcase
    if (advance) idx_d = (idx_q == IDX_W'(N_COL - 1)) ? '0 : idx_q + IDX_W'(1);
  end

  // White is code 7, off is code 0, palette entries are index+1.
  always_comb begin
    code = 3'b000;
    case (bus.mode)
      MODE_WHITE: code = 3'b111;
      MODE_OFF:   code = 3'b000;
      default:    code = 3'(idx_q) + 3'd1;
    endcase
    target = LIGHT_W'(code_to_rgb(code, CH_W));
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    light_channel_ramp #(
      .CH_W      (CH_W),
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .target (target[c*CH_W +: CH_W]),
      .value  (light_q[c*CH_W +: CH_W]),
      .ramp   (ramp[c])
    );
  end

  assign bus.light      = light_q;
  assign bus.colour_idx = idx_q;
  assign bus.changing   = (|ramp) & ~rst;

endmodule
